// File: rtl/arp_resolver.sv
// ---------------------------------------------------------------------------
// arp_resolver
//
// Resolves the next-hop MAC address for the IPv4 transmit path. A request
// from IP TX is mapped to its next hop (the destination itself when it is on
// the local subnet, otherwise the gateway), answered directly for broadcast
// destinations, answered from a small fully-associative IP->MAC cache on a
// hit, and otherwise resolved by issuing ARP queries to the frame generator
// and waiting for a matching reply from the frame parser, with retries and a
// final error response.
//
// Ports
//   clk_i / rst_i            clock, synchronous active-high reset
//   arp_request_*            lookup request from IP TX (valid/ready, ip)
//   arp_response_*           lookup result to IP TX (valid/ready, error, mac)
//   query_*                  ARP request to the frame generator (valid/ready, ip)
//   learn_*                  sender IP/MAC pulses from the ARP frame parser
//   clear_cache_i            one-cycle pulse invalidating every cache entry
//   local_ip_i, gateway_ip_i,
//   subnet_mask_i            static configuration
// ---------------------------------------------------------------------------
module arp_resolver #(
    parameter int CACHE_ENTRIES  = 4,
    parameter int RETRY_INTERVAL = 1250000,
    parameter int RETRY_COUNT    = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        arp_request_valid_i,
    output logic        arp_request_ready_o,
    input  logic [31:0] arp_request_ip_i,
    output logic        arp_response_valid_o,
    input  logic        arp_response_ready_i,
    output logic        arp_response_error_o,
    output logic [47:0] arp_response_mac_o,
    output logic        query_valid_o,
    input  logic        query_ready_i,
    output logic [31:0] query_ip_o,
    input  logic        learn_valid_i,
    input  logic [31:0] learn_ip_i,
    input  logic [47:0] learn_mac_i,
    input  logic        clear_cache_i,
    input  logic [31:0] local_ip_i,
    input  logic [31:0] gateway_ip_i,
    input  logic [31:0] subnet_mask_i
);

    localparam int PTR_W   = (CACHE_ENTRIES > 1) ? $clog2(CACHE_ENTRIES) : 1;
    localparam int TIMER_W = (RETRY_INTERVAL > 1) ? $clog2(RETRY_INTERVAL) : 1;
    localparam int RETRY_W = $clog2(RETRY_COUNT + 1);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RETRY_INTERVAL - 1);
    localparam logic [RETRY_W-1:0] RETRY_LOAD = RETRY_W'(RETRY_COUNT);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        QUERY,
        WAIT,
        RESPOND
    } state_t;

    state_t               state_q;
    logic [31:0]          target_ip_q;
    logic                 is_bcast_q;
    logic [TIMER_W-1:0]   timer_q;
    logic [RETRY_W-1:0]   retries_q;
    logic                 resp_valid_q;
    logic                 resp_error_q;
    logic [47:0]          resp_mac_q;
    logic                 query_valid_q;
    logic [31:0]          query_ip_q;

    logic [CACHE_ENTRIES-1:0] valid_q;
    logic [CACHE_ENTRIES-1:0] valid_d;
    logic [31:0]              ip_q  [CACHE_ENTRIES];
    logic [47:0]              mac_q [CACHE_ENTRIES];
    logic [PTR_W-1:0]         ptr_q;
    logic [PTR_W-1:0]         ptr_d;

    logic                 req_on_subnet;
    logic                 req_bcast;
    logic [31:0]          req_target;
    logic                 hit;
    logic [47:0]          hit_mac;
    logic                 learn_for_target;
    logic                 learn_ok;
    logic                 learn_match;
    logic [PTR_W-1:0]     learn_idx;
    logic                 wr_en;
    logic [PTR_W-1:0]     wr_idx;

    assign arp_request_ready_o  = (state_q == IDLE) && !rst_i;
    assign arp_response_valid_o = resp_valid_q;
    assign arp_response_error_o = resp_error_q;
    assign arp_response_mac_o   = resp_mac_q;
    assign query_valid_o        = query_valid_q;
    assign query_ip_o           = query_ip_q;

    // Next-hop selection: on-subnet destinations are resolved directly,
    // everything else is sent to the gateway. A subnet-directed broadcast
    // only counts as broadcast when it belongs to our own subnet.
    assign req_on_subnet = (arp_request_ip_i & subnet_mask_i) == (local_ip_i & subnet_mask_i);
    assign req_target    = req_on_subnet ? arp_request_ip_i : gateway_ip_i;
    assign req_bcast     = (arp_request_ip_i == 32'hFFFF_FFFF) ||
                           (((arp_request_ip_i | subnet_mask_i) == 32'hFFFF_FFFF) && req_on_subnet);

    // A parser pulse for the address we are resolving short-circuits both
    // the lookup and the reply wait, whether or not the cache stores it.
    assign learn_for_target = learn_valid_i && (learn_ip_i == target_ip_q);

    // Senders with a null IP or a group/broadcast MAC are never cached.
    assign learn_ok = learn_valid_i && (learn_ip_i != 32'd0) &&
                      (learn_mac_i != 48'hFFFF_FFFF_FFFF) && !learn_mac_i[40];

    always_comb begin
        hit     = 1'b0;
        hit_mac = '0;
        for (int i = 0; i < CACHE_ENTRIES; i++) begin
            if (valid_q[i] && (ip_q[i] == target_ip_q)) begin
                hit     = 1'b1;
                hit_mac = mac_q[i];
            end
        end
    end

    always_comb begin
        learn_match = 1'b0;
        learn_idx   = '0;
        for (int i = 0; i < CACHE_ENTRIES; i++) begin
            if (valid_q[i] && (ip_q[i] == learn_ip_i)) begin
                learn_match = 1'b1;
                learn_idx   = PTR_W'(i);
            end
        end
    end

    // A clear wipes the valid bits before a same-cycle learn is applied, so
    // in that case no old entry can match and the learn takes a fresh slot.
    always_comb begin
        valid_d = valid_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        if (clear_cache_i) begin
            valid_d = '0;
        end
        if (learn_ok) begin
            wr_en = 1'b1;
            if (learn_match && !clear_cache_i) begin
                wr_idx = learn_idx;
            end else begin
                wr_idx = ptr_q;
                ptr_d  = ptr_q + PTR_W'(1);
            end
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    // Entry payloads need no reset; they are qualified by valid_q.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            ip_q[wr_idx]  <= learn_ip_i;
            mac_q[wr_idx] <= learn_mac_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            target_ip_q   <= '0;
            is_bcast_q    <= 1'b0;
            timer_q       <= '0;
            retries_q     <= '0;
            resp_valid_q  <= 1'b0;
            resp_error_q  <= 1'b0;
            resp_mac_q    <= '0;
            query_valid_q <= 1'b0;
            query_ip_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arp_request_valid_i) begin
                        target_ip_q <= req_target;
                        is_bcast_q  <= req_bcast;
                        state_q     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (is_bcast_q) begin
                        resp_mac_q   <= 48'hFFFF_FFFF_FFFF;
                        resp_error_q <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESPOND;
                    end else if (learn_for_target) begin
                        // The in-flight learn is newer than any cached copy.
                        resp_mac_q   <= learn_mac_i;
                        resp_error_q <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESPOND;
                    end else if (hit) begin
                        resp_mac_q   <= hit_mac;
                        resp_error_q <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESPOND;
                    end else begin
                        retries_q     <= RETRY_LOAD;
                        query_valid_q <= 1'b1;
                        query_ip_q    <= target_ip_q;
                        state_q       <= QUERY;
                    end
                end
                QUERY: begin
                    if (query_ready_i) begin
                        query_valid_q <= 1'b0;
                        retries_q     <= retries_q - RETRY_W'(1);
                        timer_q       <= '0;
                        state_q       <= WAIT;
                    end
                end
                WAIT: begin
                    timer_q <= timer_q + TIMER_W'(1);
                    if (learn_for_target) begin
                        resp_mac_q   <= learn_mac_i;
                        resp_error_q <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESPOND;
                    end else if (timer_q == TIMER_LAST) begin
                        if (retries_q != '0) begin
                            query_valid_q <= 1'b1;
                            state_q       <= QUERY;
                        end else begin
                            resp_mac_q   <= '0;
                            resp_error_q <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESPOND;
                        end
                    end
                end
                RESPOND: begin
                    if (arp_response_ready_i) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/arp_resolver.md
# arp_resolver

Resolves next-hop MAC addresses for the IPv4 transmit path. It sits directly upstream of the IP TX block and serves that block's ARP request/response handshake. It holds a small fully-associative IP→MAC cache and answers hits from it; on a miss it issues query requests to the ARP frame generator, learns replies from the ARP frame parser, and retries until a timeout. Limited broadcast, subnet broadcast and off-subnet routing through the gateway are handled here.

## Interface
- CACHE_ENTRIES, 4: cache depth; power of two, 2..16.
- RETRY_INTERVAL, 1250000: cycles to wait for a reply after each query handshake.
- RETRY_COUNT, 3: total queries sent before reporting an error; ≥1.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- arp_request_valid  in  1  lookup request from IP TX.
- arp_request_ready  out  1  request accepted when both valid and ready are high.
- arp_request_ip  in  32  destination IP to resolve.
- arp_response_valid  out  1  result valid; held until accepted.
- arp_response_ready  in  1  result accepted when both valid and ready are high.
- arp_response_error  out  1  resolution failed; qualified by valid.
- arp_response_mac  out  48  resolved MAC; qualified by valid.
- query_valid  out  1  ARP request to the frame generator.
- query_ready  in  1  generator accepts the query.
- query_ip  out  32  IP to query; stable while query_valid is high.
- learn_valid  in  1  one-cycle pulse from the ARP parser; no backpressure.
- learn_ip  in  32  sender IP of the parsed ARP frame.
- learn_mac  in  48  sender MAC of the parsed ARP frame.
- clear_cache  in  1  one-cycle pulse that invalidates all entries.
- local_ip  in  32  configuration; must be held static during traffic.
- gateway_ip  in  32  configuration; must be held static during traffic.
- subnet_mask  in  32  configuration; must be held static during traffic.

## Operation
**States:** IDLE, LOOKUP, QUERY, WAIT, RESPOND.

**IDLE**
- arp_request_ready = 1 (combinational on state).
- On accept, latch target_ip:
  - target_ip = arp_request_ip if `(arp_request_ip & subnet_mask) == (local_ip & subnet_mask)`;
  - otherwise target_ip = gateway_ip.
- Also latch is_bcast, true when either:
  - arp_request_ip == 32'hFFFFFFFF, or
  - `(arp_request_ip | subnet_mask) == 32'hFFFFFFFF` and the IP is on-subnet.
- Go to LOOKUP.

**LOOKUP** (one cycle). Evaluate in priority order:
1. is_bcast → mac = 48'hFFFFFFFFFFFF, error = 0 → RESPOND.
2. A valid entry with ip == target_ip, or learn_valid with learn_ip == target_ip this cycle → that MAC, error = 0 → RESPOND.
3. Otherwise load retries_left = RETRY_COUNT and go to QUERY.

**QUERY**
- query_valid = 1, query_ip = target_ip.
- On handshake: decrement retries_left, clear the timer, go to WAIT.

**WAIT**
- The timer increments every cycle.
- learn_valid with learn_ip == target_ip → mac = learn_mac, error = 0 → RESPOND. This is checked before timeout in the same cycle.
- Timer reaches RETRY_INTERVAL−1:
  - if retries_left ≠ 0 → QUERY;
  - else mac = 0, error = 1 → RESPOND.

**RESPOND**
- arp_response_valid = 1 with mac/error held.
- On handshake → IDLE.

**Cache**
- Learning runs in every state, independent of the FSM.
- A learn_valid pulse is ignored when:
  - learn_ip == 0,
  - learn_mac == 48'hFFFFFFFFFFFF, or
  - learn_mac[40] (the multicast bit) == 1.
- Otherwise, if a valid entry matches learn_ip, overwrite its MAC in place; the replacement pointer is unchanged.
- Otherwise, write to the entry at the replacement pointer, set it valid, and advance the pointer modulo CACHE_ENTRIES (round-robin, wraps to 0).
- clear_cache clears every valid bit. If clear_cache and a learn arrive in the same cycle, the clear applies first and the learned entry is then written valid. The pointer is not reset by clear_cache.
- clear_cache does not affect an in-progress resolution.

**Reset**
- state = IDLE; all valid bits = 0; pointer = 0; timer = 0; retries_left = 0.
- arp_request_ready = 0 while rst is high, and 1 in the first cycle after rst deasserts.
- arp_response_valid = 0, arp_response_error = 0, arp_response_mac = 0.
- query_valid = 0, query_ip = 0.
- rst asserted mid-resolution abandons the request; no response is produced.

## Timing
- Outputs other than arp_request_ready are registered.
- Cache-hit latency: accept at cycle N → arp_response_valid high at N+2.
- Miss: query_valid is high at N+2.
- A learn reply with matching IP at cycle M in WAIT → arp_response_valid at M+1.
- A learn written at cycle M is visible to a LOOKUP at M+1. A learn in the LOOKUP cycle itself is caught by the bypass.
- Failure latency after the first query handshake is RETRY_COUNT × RETRY_INTERVAL cycles, plus query handshake stalls.
- One request is outstanding at a time. No new request is accepted until the RESPOND handshake completes.
- The response handshake may stall indefinitely; outputs stay stable while stalled.

## Test plan
- **Hit.** Config: local 192.168.1.10, mask 255.255.255.0. Learn 192.168.1.20 → 02:00:00:00:00:14. Request 192.168.1.20 → response at accept+2 with mac 02:00:00:00:00:14, error 0, and no query_valid.
- **Miss then reply.** Request 192.168.1.30 → query_valid with query_ip C0A8011E. After the handshake, pulse learn (192.168.1.30, 02:00:00:00:00:1E) 10 cycles later → response with that MAC one cycle later. A repeat request hits.
- **Timeout.** RETRY_INTERVAL=16, RETRY_COUNT=3, no learn → exactly 3 query handshakes, then error=1, mac=0. Hold arp_response_ready low for 5 cycles and check outputs stay stable.
- **Routing and broadcast.**
  - Request 10.0.0.1 with gateway 192.168.1.1 → query_ip C0A80101.
  - Request 255.255.255.255 and 192.168.1.255 → mac FFFFFFFFFFFF at accept+2, no query.
- **Replacement and clear.**
  - CACHE_ENTRIES=4: learn 5 distinct IPs → the first IP misses and the other 4 hit. Re-learn an existing IP with a new MAC → updated in place, pointer unchanged.
  - clear_cache with a simultaneous learn → only the learned IP hits.
  - Learns with multicast or broadcast MAC are ignored.
- **Reset mid-WAIT.** Assert rst for 1 cycle → no response. Next cycle: arp_request_ready=1, query_valid=0, and all earlier entries miss.
